// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - N-bit two's-complement adder/subtractor with registered result
module adder_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    output logic [N-1:0] y,
    output logic         carry_out,
    output logic         overflow
);

    logic [N-1:0] b_eff;
    logic [N-1:0] s;
    logic [N:0]   c;

    logic [N-1:0] y_d,     y_q;
    logic         carry_d, carry_q;
    logic         ovf_d,   ovf_q;
    logic         valid_d, valid_q;

    // Subtraction reuses the adder: a - b == a + ~b + 1, with the +1 as carry-in.
    always_comb begin
        b_eff = b ^ {N{sub}};
        s     = '0;
        c     = '0;
        c[0]  = sub;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i+1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
    end

    // Result bits only move on accepted inputs, so idle operands never reach the outputs.
    always_comb begin
        valid_d = in_valid;
        y_d     = y_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            y_d     = s;
            carry_d = c[N];
            ovf_d   = c[N] ^ c[N-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// tb/tb_adder_subtractor.sv - vector table, corner sequences and random sweep for adder_subtractor
module tb_adder_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        iv8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ov_valid8, co8, ovf8;
    logic [7:0]  y8;

    logic        iv16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ov_valid16, co16, ovf16;
    logic [15:0] y16;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    adder_subtractor #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov_valid8), .y(y8), .carry_out(co8), .overflow(ovf8)
    );

    adder_subtractor #(.N(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .sub(sub16),
        .out_valid(ov_valid16), .y(y16), .carry_out(co16), .overflow(ovf16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] y;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Returns {overflow, carry, y[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_model(input int w, input longint a, input longint b,
                                              input bit sub);
        longint one  = 1;
        longint mask = (one << w) - 1;
        longint half = one << (w - 1);
        longint r, sa, sb, sr;
        logic [15:0] yy;
        logic cc, oo;
        r  = sub ? a - b : a + b;
        yy = 16'(r & mask);
        cc = sub ? (a >= b) : (r > mask);
        sa = (a >= half) ? a - (one << w) : a;
        sb = (b >= half) ? b - (one << w) : b;
        sr = sub ? sa - sb : sa + sb;
        oo = (sr > half - 1) || (sr < -half);
        return {oo, cc, yy};
    endfunction

    function automatic logic [31:0] out8();
        return {21'd0, ov_valid8, ovf8, co8, y8};
    endfunction

    function automatic logic [31:0] out16();
        return {13'd0, ov_valid16, ovf16, co16, y16};
    endfunction

    logic [17:0] exp8, exp16, r8, r16;
    logic        expv8, expv16;

    initial begin
        vecs[0]  = '{8'd10,  8'd20,  1'b0, 8'd30,  1'b0, 1'b0};
        vecs[1]  = '{8'd20,  8'd10,  1'b1, 8'd10,  1'b1, 1'b0};
        vecs[2]  = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
        vecs[3]  = '{8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1};
        vecs[4]  = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
        vecs[5]  = '{8'd77,  8'd77,  1'b1, 8'd0,   1'b1, 1'b0};
        vecs[6]  = '{8'd0,   8'd1,   1'b1, 8'd255, 1'b0, 1'b0};
        vecs[7]  = '{8'd0,   8'd128, 1'b1, 8'd128, 1'b0, 1'b1};
        vecs[8]  = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
        vecs[9]  = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};
        vecs[10] = '{8'd5,   8'd9,   1'b1, 8'd252, 1'b0, 1'b0};
        vecs[11] = '{8'd100, 8'd50,  1'b0, 8'd150, 1'b0, 1'b1};

        #2 rst_n = 1'b0;
        #1 chk("reset8", out8(), 32'd0);
        chk("reset16", out16(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back table vectors, one result per cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            iv8 = 1'b1; a8 = vecs[i].a; b8 = vecs[i].b; sub8 = vecs[i].sub;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), out8(),
                {21'd0, 1'b1, vecs[i].o, vecs[i].c, vecs[i].y});
        end

        // 255+1 then idle: valid drops, result bits hold.
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd255; b8 = 8'd1; sub8 = 1'b0;
        @(posedge clk); #1;
        chk("wrap", out8(), {21'd0, 1'b1, 1'b0, 1'b1, 8'd0});
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'd33; b8 = 8'd44; sub8 = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold", out8(), {21'd0, 1'b0, 1'b0, 1'b1, 8'd0});
        @(posedge clk); #1;
        chk("idle_hold2", out8(), {21'd0, 1'b0, 1'b0, 1'b1, 8'd0});

        // Asynchronous reset between edges while a stream is in flight.
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd90; b8 = 8'd60; sub8 = 1'b0;
        iv16 = 1'b1; a16 = 16'd40000; b16 = 16'd30000; sub16 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst8", out8(), {21'd0, 1'b1, 1'b1, 1'b0, 8'd150});
        r16 = ref_model(16, 40000, 30000, 1'b0);
        chk("pre_rst16", out16(), {13'd0, 1'b1, r16});
        #2 rst_n = 1'b0;
        #1 chk("async_rst8", out8(), 32'd0);
        chk("async_rst16", out16(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; iv8 = 1'b0; iv16 = 1'b0;
        @(posedge clk); #1;
        chk("post_rst8", out8(), 32'd0);
        chk("post_rst16", out16(), 32'd0);

        // Random sweep against the arithmetic reference, both widths in parallel.
        exp8 = '0; exp16 = '0; expv8 = 1'b0; expv16 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            iv8   = ($urandom_range(0, 7) != 0);
            a8    = 8'($urandom);
            b8    = 8'($urandom);
            sub8  = 1'($urandom);
            iv16  = ($urandom_range(0, 7) != 0);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            sub16 = 1'($urandom);
            expv8  = iv8;
            expv16 = iv16;
            if (iv8) begin
                r8   = ref_model(8, longint'(a8), longint'(b8), sub8);
                exp8 = r8;
            end
            if (iv16) begin
                r16   = ref_model(16, longint'(a16), longint'(b16), sub16);
                exp16 = r16;
            end
            @(posedge clk); #1;
            chk($sformatf("rnd8_%0d", i), out8(),
                {21'd0, expv8, exp8[17], exp8[16], exp8[7:0]});
            chk($sformatf("rnd16_%0d", i), out16(), {13'd0, expv16, exp16});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
